// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle of pipeline-side signals exchanged with the hazard
//               controller. The master modport is the pipeline (drives the
//               register specifiers and control flags, receives the stall /
//               forward decisions); the slave modport is hazard_ctrl.
//   Pipeline -> controller : rsd, rtd, rse, rte, writerege/m/w,
//                            regwritee/m/w, memtorege/m, branchd, shiftm/w,
//                            mdstartd, mdstarte, mdreadd, stallclr
//   Controller -> pipeline : stallf, stalld, flushe, forwardad, forwardbd,
//                            forwardae, forwardbe, mdbusy, mddone, stallcnt
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int REGW = 5,
  parameter int CNTW = 16
);
  // register specifiers
  logic [REGW-1:0] rsd;
  logic [REGW-1:0] rtd;
  logic [REGW-1:0] rse;
  logic [REGW-1:0] rte;
  logic [REGW-1:0] writerege;
  logic [REGW-1:0] writeregm;
  logic [REGW-1:0] writeregw;
  // per-stage control flags
  logic            regwritee;
  logic            regwritem;
  logic            regwritew;
  logic            memtorege;
  logic            memtoregm;
  logic            branchd;
  logic            shiftm;
  logic            shiftw;
  // multiply/divide control
  logic            mdstartd;
  logic            mdstarte;
  logic            mdreadd;
  logic            stallclr;
  // controller decisions
  logic            stallf;
  logic            stalld;
  logic            flushe;
  logic            forwardad;
  logic            forwardbd;
  logic [2:0]      forwardae;
  logic [2:0]      forwardbe;
  logic            mdbusy;
  logic            mddone;
  logic [CNTW-1:0] stallcnt;

  modport master (
    output rsd, rtd, rse, rte, writerege, writeregm, writeregw,
    output regwritee, regwritem, regwritew, memtorege, memtoregm,
    output branchd, shiftm, shiftw, mdstartd, mdstarte, mdreadd, stallclr,
    input  stallf, stalld, flushe, forwardad, forwardbd,
    input  forwardae, forwardbe, mdbusy, mddone, stallcnt
  );

  modport slave (
    input  rsd, rtd, rse, rte, writerege, writeregm, writeregw,
    input  regwritee, regwritem, regwritew, memtorege, memtoregm,
    input  branchd, shiftm, shiftw, mdstartd, mdstarte, mdreadd, stallclr,
    output stallf, stalld, flushe, forwardad, forwardbd,
    output forwardae, forwardbe, mdbusy, mddone, stallcnt
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard unit for a five-stage pipeline with a multi-cycle
//               multiply/divide unit. Produces operand forwarding selects,
//               load-use / branch / mult-div stalls, tracks the mult/div
//               occupancy with a small FSM and counts stalled cycles.
// Ports       :
//   clk    - single clock, all state on rising edge
//   resetn - synchronous active-low reset
//   hz     - hazard_ctrl_if.slave bundle (specifiers, flags, decisions)
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REGW      = 5,
  parameter int MD_CYCLES = 32,
  parameter int CNTW      = 16
) (
  input  logic          clk,
  input  logic          resetn,
  hazard_ctrl_if.slave  hz
);

  // Counter wide enough for MD_CYCLES-1; guard the degenerate width.
  localparam int c_md_cw = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
  localparam logic [c_md_cw-1:0] c_md_load = c_md_cw'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  // --------------------------------------------------------------------------
  // Execute operand forwarding. Memory stage wins over Writeback because it
  // holds the younger result. Bit 2 flags a shift result so the mux can pick
  // the shifter path instead of the ALU path.
  // --------------------------------------------------------------------------
  function automatic logic [2:0] fwd_sel(
    input logic [REGW-1:0] src,
    input logic [REGW-1:0] wreg_m,
    input logic            rw_m,
    input logic            sh_m,
    input logic [REGW-1:0] wreg_w,
    input logic            rw_w,
    input logic            sh_w
  );
    logic [2:0] sel;
    sel = 3'b000;
    if ((src != '0) && (src == wreg_m) && rw_m) begin
      sel = sh_m ? 3'b110 : 3'b010;
    end else if ((src != '0) && (src == wreg_w) && rw_w) begin
      sel = sh_w ? 3'b101 : 3'b001;
    end
    return sel;
  endfunction

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  md_state_t          state_q,    state_d;
  logic [c_md_cw-1:0] mdcnt_q,    mdcnt_d;
  logic               mdbusy_q,   mdbusy_d;
  logic               mddone_q,   mddone_d;
  logic [CNTW-1:0]    stallcnt_q, stallcnt_d;

  // --------------------------------------------------------------------------
  // Stall detection (purely combinational, same-cycle)
  // --------------------------------------------------------------------------
  logic lwstall;
  logic branchstall;
  logic mdstall;
  logic stall;

  always_comb begin
    lwstall = hz.memtorege & ((hz.rsd == hz.rte) | (hz.rtd == hz.rte));

    // Branch compares in Decode need operands that are still being produced
    // by an ALU op in Execute or a load in Memory.
    branchstall = hz.branchd &
                  ((hz.regwritee & ((hz.writerege == hz.rsd) | (hz.writerege == hz.rtd))) |
                   (hz.memtoregm & ((hz.writeregm == hz.rsd) | (hz.writeregm == hz.rtd))));

    // Gated by resetn so a reset applied mid-operation drops the stall
    // immediately rather than one edge later.
    mdstall = (hz.mdreadd | hz.mdstartd) & (state_q == BUSY) & resetn;

    stall = lwstall | branchstall | mdstall;
  end

  assign hz.stallf    = stall;
  assign hz.stalld    = stall;
  assign hz.flushe    = stall;

  assign hz.forwardad = (hz.rsd != '0) & (hz.rsd == hz.writeregm) & hz.regwritem;
  assign hz.forwardbd = (hz.rtd != '0) & (hz.rtd == hz.writeregm) & hz.regwritem;

  assign hz.forwardae = fwd_sel(hz.rse, hz.writeregm, hz.regwritem, hz.shiftm,
                                hz.writeregw, hz.regwritew, hz.shiftw);
  assign hz.forwardbe = fwd_sel(hz.rte, hz.writeregm, hz.regwritem, hz.shiftm,
                                hz.writeregw, hz.regwritew, hz.shiftw);

  // --------------------------------------------------------------------------
  // Mult/div occupancy FSM next-state. The counter is loaded with
  // MD_CYCLES-1 and BUSY is left once it has reached zero, so BUSY spans
  // exactly MD_CYCLES cycles. A new start arriving while BUSY is dropped;
  // one arriving in DONE chains straight into another operation.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mdcnt_d = mdcnt_q;
    case (state_q)
      IDLE: begin
        if (hz.mdstarte) begin
          state_d = BUSY;
          mdcnt_d = c_md_load;
        end
      end
      BUSY: begin
        if (mdcnt_q == '0) begin
          state_d = DONE;
        end else begin
          mdcnt_d = mdcnt_q - 1'b1;
        end
      end
      DONE: begin
        if (hz.mdstarte) begin
          state_d = BUSY;
          mdcnt_d = c_md_load;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        mdcnt_d = '0;
      end
    endcase

    mdbusy_d = (state_d == BUSY);
    mddone_d = (state_d == DONE);
  end

  // --------------------------------------------------------------------------
  // Stalled-cycle counter: clear beats increment, saturates at all-ones.
  // --------------------------------------------------------------------------
  always_comb begin
    stallcnt_d = stallcnt_q;
    if (hz.stallclr) begin
      stallcnt_d = '0;
    end else if (stall && (stallcnt_q != '1)) begin
      stallcnt_d = stallcnt_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      mdcnt_q    <= '0;
      mdbusy_q   <= 1'b0;
      mddone_q   <= 1'b0;
      stallcnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mdcnt_q    <= mdcnt_d;
      mdbusy_q   <= mdbusy_d;
      mddone_q   <= mddone_d;
      stallcnt_q <= stallcnt_d;
    end
  end

  // Status flags are forced low while reset is held, even before the
  // reset edge has cleared the FSM.
  assign hz.mdbusy   = mdbusy_q & resetn;
  assign hz.mddone   = mddone_q & resetn;
  assign hz.stallcnt = stallcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl with
//               MD_CYCLES=4 and CNTW=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic clk;
  logic resetn;
  int   errors;
  int   checks;

  hazard_ctrl_if #(.REGW(5), .CNTW(4)) hz ();

  hazard_ctrl #(
    .REGW      (5),
    .MD_CYCLES (4),
    .CNTW      (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .hz     (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rsd = '0; hz.rtd = '0; hz.rse = '0; hz.rte = '0;
    hz.writerege = '0; hz.writeregm = '0; hz.writeregw = '0;
    hz.regwritee = 1'b0; hz.regwritem = 1'b0; hz.regwritew = 1'b0;
    hz.memtorege = 1'b0; hz.memtoregm = 1'b0; hz.branchd = 1'b0;
    hz.shiftm = 1'b0; hz.shiftw = 1'b0;
    hz.mdstartd = 1'b0; hz.mdstarte = 1'b0; hz.mdreadd = 1'b0;
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check({tag, "_stallf"}, hz.stallf, exp);
    check({tag, "_stalld"}, hz.stalld, exp);
    check({tag, "_flushe"}, hz.flushe, exp);
  endtask

  // Watchdog: the sequence is bounded by clock edges, this only guards
  // against a broken simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    errors = 0;
    checks = 0;
    clear_inputs();
    hz.stallclr = 1'b0;
    resetn = 1'b0;

    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    check("rst_mdbusy",   hz.mdbusy,   1'b0);
    check("rst_mddone",   hz.mddone,   1'b0);
    check("rst_stallcnt", hz.stallcnt, 4'd0);
    check("rst_stallf",   hz.stallf,   1'b0);
    resetn = 1'b1;
    hz.stallclr = 1'b1;  // keep counter at zero during combinational checks

    // ---------------- execute forwarding ----------------
    @(negedge clk);
    hz.rse = 5'd3; hz.writeregm = 5'd3; hz.regwritem = 1'b1; hz.shiftm = 1'b1;
    hz.writeregw = 5'd3; hz.regwritew = 1'b1;
    #1 check("fae_mem_shift", hz.forwardae, 3'b110);
    check("fbe_r0", hz.forwardbe, 3'b000);
    hz.regwritem = 1'b0;
    #1 check("fae_wb", hz.forwardae, 3'b001);
    hz.shiftw = 1'b1;
    #1 check("fae_wb_shift", hz.forwardae, 3'b101);
    hz.rse = 5'd0;
    #1 check("fae_r0", hz.forwardae, 3'b000);
    hz.rte = 5'd3; hz.regwritem = 1'b1; hz.shiftm = 1'b0;
    #1 check("fbe_mem_alu", hz.forwardbe, 3'b010);

    // ---------------- decode forwarding ----------------
    hz.rsd = 5'd3; hz.rtd = 5'd0; hz.writeregm = 5'd3;
    #1 check("fad_mem", hz.forwardad, 1'b1);
    check("fbd_r0", hz.forwardbd, 1'b0);
    hz.rtd = 5'd3; hz.regwritem = 1'b0;
    #1 check("fad_nowrite", hz.forwardad, 1'b0);
    check("fbd_nowrite", hz.forwardbd, 1'b0);

    // ---------------- load-use stall ----------------
    @(negedge clk);
    clear_inputs();
    hz.memtorege = 1'b1; hz.rte = 5'd7; hz.rsd = 5'd7;
    #1 check_stall("lw_rs", 1'b1);
    hz.memtorege = 1'b0;
    #1 check_stall("lw_off", 1'b0);
    hz.memtorege = 1'b1; hz.rsd = 5'd1; hz.rtd = 5'd7;
    #1 check_stall("lw_rt", 1'b1);
    hz.rtd = 5'd2;
    #1 check_stall("lw_nomatch", 1'b0);

    // ---------------- branch stall ----------------
    @(negedge clk);
    clear_inputs();
    hz.branchd = 1'b1; hz.regwritee = 1'b1; hz.writerege = 5'd4; hz.rtd = 5'd4;
    hz.rsd = 5'd9;
    #1 check_stall("br_ex", 1'b1);
    hz.regwritee = 1'b0; hz.memtoregm = 1'b1; hz.writeregm = 5'd4;
    #1 check_stall("br_mem", 1'b1);
    hz.memtoregm = 1'b0;
    #1 check_stall("br_none", 1'b0);
    hz.memtoregm = 1'b1; hz.branchd = 1'b0;
    #1 check_stall("br_nobranch", 1'b0);

    // ---------------- mult/div latency ----------------
    @(negedge clk);
    clear_inputs();
    @(negedge clk);              // edge with stallclr=1 leaves counter at 0
    hz.stallclr = 1'b0;
    check("md_cnt_start", hz.stallcnt, 4'd0);
    hz.mdreadd = 1'b1; hz.mdstarte = 1'b1;
    #1 check("md_idle_nostall", hz.stallf, 1'b0);
    @(negedge clk);              // start accepted on this edge
    hz.mdstarte = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("md_busy_%0d", i), hz.mdbusy, (i < 4) ? 1'b1 : 1'b0);
      check($sformatf("md_done_%0d", i), hz.mddone, (i == 4) ? 1'b1 : 1'b0);
      check($sformatf("md_stall_%0d", i), hz.stallf, (i < 4) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    check("md_stallcnt", hz.stallcnt, 4'd4);

    // ---------------- reset during BUSY ----------------
    hz.mdstarte = 1'b1;
    @(negedge clk);
    hz.mdstarte = 1'b0;
    #1 check("rb_busy", hz.mdbusy, 1'b1);
    @(negedge clk);
    resetn = 1'b0;
    #1 check("rb_stall_in_rst", hz.stallf, 1'b0);
    check("rb_busy_in_rst", hz.mdbusy, 1'b0);
    @(negedge clk);
    check("rb_busy_after", hz.mdbusy, 1'b0);
    check("rb_done_after", hz.mddone, 1'b0);
    check("rb_cnt_after", hz.stallcnt, 4'd0);
    resetn = 1'b1;
    hz.mdreadd = 1'b0;

    // ---------------- back-to-back through DONE ----------------
    hz.mdstarte = 1'b1;
    @(negedge clk);
    hz.mdstarte = 1'b0;
    repeat (4) @(negedge clk);
    check("bb_done", hz.mddone, 1'b1);
    hz.mdstarte = 1'b1;
    @(negedge clk);
    hz.mdstarte = 1'b0;
    check("bb_rebusy", hz.mdbusy, 1'b1);
    check("bb_done_single", hz.mddone, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bb_busy_%0d", i), hz.mdbusy, 1'b1);
    end
    @(negedge clk);
    check("bb_done2", hz.mddone, 1'b1);
    check("bb_idle_busy", hz.mdbusy, 1'b0);
    @(negedge clk);
    check("bb_idle_done", hz.mddone, 1'b0);

    // ---------------- stall counter saturation ----------------
    clear_inputs();
    hz.memtorege = 1'b1; hz.rsd = 5'd7; hz.rte = 5'd7;
    hz.stallclr = 1'b1;
    @(negedge clk);
    check("sat_clr0", hz.stallcnt, 4'd0);
    hz.stallclr = 1'b0;
    repeat (5) @(negedge clk);
    check("sat_cnt5", hz.stallcnt, 4'd5);
    repeat (15) @(negedge clk);
    check("sat_cnt15", hz.stallcnt, 4'd15);
    hz.stallclr = 1'b1;
    @(negedge clk);
    check("sat_clr_prio", hz.stallcnt, 4'd0);
    hz.stallclr = 1'b0;
    @(negedge clk);
    check("sat_restart", hz.stallcnt, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REGW, default 5, register-specifier width.
REQ-002 Parameter MD_CYCLES, default 32, multiply/divide latency in cycles (>=2).
REQ-003 Parameter CNTW, default 16, stall performance counter width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 resetn  in  1  synchronous, active-low reset.
REQ-006 rsd, rtd, rse, rte  in  REGW each  source specifiers in Decode and Execute.
REQ-007 writerege, writeregm, writeregw  in  REGW each  destination specifiers in Execute, Memory and Writeback.
REQ-008 regwritee, regwritem, regwritew, memtorege, memtoregm, branchd, shiftm, shiftw  in  1 each  per-stage control flags.
REQ-009 mdstartd, mdstarte  in  1 each  mult/div instruction in Decode / Execute.
REQ-010 mdreadd  in  1  mfhi/mflo in Decode.
REQ-011 stallclr  in  1  clears the stall counter.
REQ-012 stallf, stalld, flushe  out  1 each  fetch stall, decode stall, execute flush.
REQ-013 forwardad, forwardbd  out  1 each  Decode comparator forward from Memory.
REQ-014 forwardae, forwardbe  out  3 each  Execute ALU operand forward select.
REQ-015 mdbusy  out  1  mult/div unit occupied; mddone  out  1  one-cycle result-ready pulse.
REQ-016 stallcnt  out  CNTW  saturating count of stalled cycles.

Function
REQ-017 forwardae SHALL be: rse!=0, rse==writeregm, regwritem -> 110 if shiftm else 010; else rse!=0, rse==writeregw, regwritew -> 101 if shiftw else 001; else 000; Memory priority over Writeback.
REQ-018 forwardbe SHALL follow REQ-017 with rte in place of rse.
REQ-019 forwardad = rsd!=0 & rsd==writeregm & regwritem; forwardbd identical with rtd.
REQ-020 lwstall = memtorege & (rsd==rte | rtd==rte).
REQ-021 branchstall = branchd & ((regwritee & (writerege==rsd | writerege==rtd)) | (memtoregm & (writeregm==rsd | writeregm==rtd))).
REQ-022 mdstall = (mdreadd | mdstartd) & (state==BUSY).
REQ-023 stallf = stalld = flushe = lwstall | branchstall | mdstall, combinational in the same cycle.
REQ-024 Mult/div FSM states IDLE, BUSY, DONE; mdbusy = (state==BUSY); mddone = (state==DONE).
REQ-025 IDLE -> BUSY when mdstarte=1, loading counter with MD_CYCLES-1; else stay IDLE.
REQ-026 BUSY: counter decrements each cycle; at counter==0 -> DONE next edge; mdstarte ignored in BUSY.
REQ-027 DONE lasts exactly one cycle; DONE -> BUSY (counter reload) if mdstarte=1, else -> IDLE.
REQ-028 Counter width SHALL be clog2(MD_CYCLES); an operation occupies BUSY for exactly MD_CYCLES cycles.
REQ-029 stallcnt increments by 1 on each edge where stallf=1, holds at all-ones (no wrap).
REQ-030 stallclr=1 sets stallcnt to 0 on the next edge, taking priority over increment.
REQ-031 All forward/stall outputs are combinational from inputs and FSM state; no cycle of latency.

Reset
REQ-032 resetn=0 at a rising edge SHALL force state=IDLE, counter=0, stallcnt=0, overriding all other inputs including a mid-operation BUSY.
REQ-033 During and immediately after reset, mdbusy=0 and mddone=0; combinational outputs follow inputs per REQ-017..023 with mdstall=0.

Verification
REQ-034 rse=3, writeregm=3, regwritem=1, shiftm=1, writeregw=3, regwritew=1 -> forwardae=110; set regwritem=0 -> 001; rse=0 -> 000.
REQ-035 memtorege=1, rte=7, rsd=7 -> stallf=stalld=flushe=1; memtorege=0 -> all 0.
REQ-036 branchd=1, regwritee=1, writerege=rtd=4 -> stall=1; change to memtoregm=1, writeregm=4, regwritee=0 -> stall=1.
REQ-037 MD_CYCLES=4: mdstarte pulse -> mdbusy=1 for 4 cycles, mddone=1 on 5th; mdreadd=1 throughout -> stallf=1 only while mdbusy=1.
REQ-038 Reset asserted during BUSY -> next edge mdbusy=0, stallcnt=0; mdstarte in DONE cycle -> BUSY re-entered, mddone single cycle.
REQ-039 CNTW=4: hold a stall 20 cycles -> stallcnt saturates at 15; stallclr with stall active -> 0.
